dual_issue_dispatch: RTL

//  Issue stage feeding the even/odd execution pipes. Fetches an instruction pair at the PC and routes each

---
 rtl/dual_issue_dispatch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dual_issue_dispatch.sv
// -----------------------------------------------------------------------------
// dual_issue_dispatch
//
// Issue stage in front of the even/odd execution pipes. Each cycle it looks at
// the instruction pair at the PC (slot 0 at pc, slot 1 at pc+1) and sends each
// instruction to the pipe it targets. Both slots go out together when that is
// legal; otherwise only slot 0 goes out, or nothing does. A slot is held back
// while one of its sources is still waiting to be written back by the pipes. A
// taken branch loads the PC from the pipes and inserts NOP pairs while the
// pipes flush. A stop instruction parks the stage until a branch or a reset.
//
// Ports
//   clock, reset            rising-edge clock; synchronous active-high reset
//   fetch_address           PC of slot 0; memory returns PC and PC+1 (mod 256)
//   fetch_word_0/1          instruction words at PC / PC+1 (combinational)
//   slot_is_odd             per slot: 1 = slot targets the odd pipe
//   slot_src_address/used   per slot, three source register addresses + valids
//   slot_rt_address         per slot destination register
//   slot_register_write     per slot: slot writes its destination
//   pending_rt_address      destinations still in flight in the pipes
//   pending_register_write  valid flag per in-flight destination
//   branch_is_taken         taken branch reported by the odd pipe
//   program_counter_wb      branch target
//   instruction_even/odd    registered instruction for each pipe
//   initial_odd             odd-pipe instruction comes first in program order
//   program_counter         PC of the instruction last sent to the odd pipe
//   halted                  stage is parked on a stop instruction
// -----------------------------------------------------------------------------
module dual_issue_dispatch #(
  parameter int          PENDING_DEPTH = 29,
  parameter int          FLUSH_CYCLES  = 2,
  parameter logic [0:31] NOP_EVEN      = 32'h40200000,
  parameter logic [0:31] NOP_ODD       = 32'h00200000
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic [7:0]                        fetch_address,
  input  logic [0:31]                       fetch_word_0,
  input  logic [0:31]                       fetch_word_1,
  input  logic [1:0]                        slot_is_odd,
  input  logic [1:0][2:0][0:6]              slot_src_address,
  input  logic [1:0][2:0]                   slot_src_used,
  input  logic [1:0][0:6]                   slot_rt_address,
  input  logic [1:0]                        slot_register_write,
  input  logic [PENDING_DEPTH-1:0][0:6]     pending_rt_address,
  input  logic [PENDING_DEPTH-1:0]          pending_register_write,
  input  logic                              branch_is_taken,
  input  logic [7:0]                        program_counter_wb,
  output logic [0:31]                       instruction_even,
  output logic [0:31]                       instruction_odd,
  output logic                              initial_odd,
  output logic [7:0]                        program_counter,
  output logic                              halted
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Last value of the flush counter before returning to ISSUE.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_e       state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [2:0]   flush_cnt_q, flush_cnt_d;
  logic [0:31]  instr_even_q, instr_even_d;
  logic [0:31]  instr_odd_q, instr_odd_d;
  logic         initial_odd_q, initial_odd_d;
  logic [7:0]   prog_cnt_q, prog_cnt_d;
  logic         halted_q, halted_d;

  logic [1:0]   hazard;
  logic         slot1_dep;
  logic         dual_ok;
  logic         stop;

  // Source-vs-scoreboard RAW check for both slots. Entries whose write flag
  // is clear are ignored whatever their address holds.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hazard = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 3; j++) begin
        for (int i = 0; i < PENDING_DEPTH; i++) begin
          if (slot_src_used[s][j] && pending_register_write[i] &&
              (pending_rt_address[i] == slot_src_address[s][j])) begin
            hazard[s] = 1'b1;
          end
        end
      end
    end
  end

  // Slot 1 cannot go out alongside slot 0 if it reads slot 0's result or
  // targets the same destination register.
  always_comb begin
    slot1_dep = 1'b0;
    if (slot_register_write[0]) begin
      for (int j = 0; j < 3; j++) begin
        if (slot_src_used[1][j] && (slot_src_address[1][j] == slot_rt_address[0])) begin
          slot1_dep = 1'b1;
        end
      end
      if (slot_rt_address[1] == slot_rt_address[0]) begin
        slot1_dep = 1'b1;
      end
    end
  end

  assign dual_ok = (slot_is_odd[0] != slot_is_odd[1]) && !hazard[0] &&
                   !hazard[1] && !slot1_dep;
  assign stop    = (fetch_word_0[0:11] == 12'd0);

  // Next-state and next-output logic. Unless a slot actually issues, both
  // pipes receive their NOP and the odd-pipe PC holds.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_cnt_d   = flush_cnt_q;
    instr_even_d  = NOP_EVEN;
    instr_odd_d   = NOP_ODD;
    initial_odd_d = 1'b0;
    prog_cnt_d    = prog_cnt_q;
    halted_d      = halted_q;

    if (branch_is_taken) begin
      // A taken branch wins over everything else, in every state.
      pc_d        = program_counter_wb;
      state_d     = ST_FLUSH;
      flush_cnt_d = 3'd0;
      halted_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ISSUE: begin
          if (stop) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (hazard[0]) begin
            // Stall: slot 1 never overtakes slot 0.
          end else if (dual_ok) begin
            instr_even_d  = slot_is_odd[0] ? fetch_word_1 : fetch_word_0;
            instr_odd_d   = slot_is_odd[0] ? fetch_word_0 : fetch_word_1;
            initial_odd_d = slot_is_odd[0];
            prog_cnt_d    = slot_is_odd[0] ? pc_q : pc_q + 8'd1;
            pc_d          = pc_q + 8'd2;
          end else begin
            if (slot_is_odd[0]) begin
              instr_odd_d   = fetch_word_0;
              initial_odd_d = 1'b1;
              prog_cnt_d    = pc_q;
            end else begin
              instr_even_d  = fetch_word_0;
            end
            pc_d = pc_q + 8'd1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = ST_ISSUE;
            flush_cnt_d = 3'd0;
          end else begin
            flush_cnt_d = flush_cnt_q + 3'd1;
          end
        end
        ST_HALT: begin
          // Parked until a branch or reset.
        end
        default: begin
          state_d = ST_ISSUE;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_ISSUE;
      pc_q          <= 8'd0;
      flush_cnt_q   <= 3'd0;
      instr_even_q  <= NOP_EVEN;
      instr_odd_q   <= NOP_ODD;
      initial_odd_q <= 1'b0;
      prog_cnt_q    <= 8'd0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_cnt_q   <= flush_cnt_d;
      instr_even_q  <= instr_even_d;
      instr_odd_q   <= instr_odd_d;
      initial_odd_q <= initial_odd_d;
      prog_cnt_q    <= prog_cnt_d;
      halted_q      <= halted_d;
    end
  end

  assign fetch_address    = pc_q;
  assign instruction_even = instr_even_q;
  assign instruction_odd  = instr_odd_q;
  assign initial_odd      = initial_odd_q;
  assign program_counter  = prog_cnt_q;
  assign halted           = halted_q;

endmodule
